// File: rtl/motion_pkg.sv
// Shared motion-control definitions: velocity word layout (two's complement,
// F fraction bits plus sign) and the watchdog-disable encoding.
package motion_pkg;

    localparam int VEL_F_DEFAULT = 10;
    localparam int WD_DISABLED   = 0;

    function automatic int vel_width(input int f);
        return f + 1;
    endfunction

    // Sign bit sits directly above the fraction bits, as in stepgen.
    function automatic int vel_sign_bit(input int f);
        return f;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Update-rate divider: one-cycle registered strobe every update_div+1 clocks.
module tick_divider #(
    parameter int D = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [D-1:0] update_div,
    output logic         tick
);

    logic [D-1:0] div_cnt;

    // >= rather than == so a lowered update_div takes effect at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt >= update_div) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + D'(1);
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/velocity_ramp.sv
// Acceleration-limited velocity source feeding stepgen: one-entry command slot,
// per-tick slew toward target, and a watchdog that ramps to zero on host loss.
module velocity_ramp
    import motion_pkg::*;
#(
    parameter int F  = VEL_F_DEFAULT,
    parameter int A  = 8,
    parameter int D  = 16,
    parameter int WD = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [F:0]    cmd_velocity,
    input  logic [A-1:0]  accel,
    input  logic [D-1:0]  update_div,
    input  logic [WD-1:0] wd_timeout,
    output logic [F:0]    velocity,
    output logic          tick,
    output logic          at_target,
    output logic          wd_tripped
);

    localparam int VW = vel_width(F);
    localparam int SB = vel_sign_bit(F);

    logic [F:0]    target, pending;
    logic          pending_flag;
    logic [WD-1:0] wd_cnt;

    logic [F:0]    target_n, pending_n, vel_n, slew_vel;
    logic          pflag_n, trip_n;
    logic [WD-1:0] wd_cnt_n;
    logic          accept, wd_term;

    logic signed [F+1:0] diff;
    logic [F+1:0]        tgt_x, vel_x, mag, acc_x;

    tick_divider #(.D(D)) u_div (
        .clk        (clk),
        .reset      (reset),
        .update_div (update_div),
        .tick       (tick)
    );

    assign accept  = cmd_valid && cmd_ready;
    assign wd_term = (wd_timeout != WD'(WD_DISABLED)) &&
                     (wd_cnt == wd_timeout - WD'(1)) && !accept;

    // One extra bit of headroom so target - velocity never wraps.
    always_comb begin
        tgt_x = {target[SB], target};
        vel_x = {velocity[SB], velocity};
        acc_x = {{(F+2-A){1'b0}}, accel};
        diff  = $signed(tgt_x) - $signed(vel_x);
        mag   = diff[F+1] ? F'(0) - diff : diff;
        if (mag <= acc_x)
            slew_vel = target;
        else if (diff[F+1])
            slew_vel = VW'(vel_x - acc_x);
        else
            slew_vel = VW'(vel_x + acc_x);
    end

    always_comb begin
        target_n  = target;
        pending_n = pending;
        pflag_n   = pending_flag;
        vel_n     = velocity;
        trip_n    = wd_tripped;
        wd_cnt_n  = wd_cnt;
        // Velocity slews toward the pre-tick target; a new target bites next tick.
        if (tick) begin
            vel_n = slew_vel;
            if (pending_flag) begin
                target_n = pending;
                pflag_n  = 1'b0;
            end
        end
        if (accept) begin
            pending_n = cmd_velocity;
            pflag_n   = 1'b1;
            trip_n    = 1'b0;
            wd_cnt_n  = '0;
        end else begin
            if (wd_cnt != '1)
                wd_cnt_n = wd_cnt + WD'(1);
            if (wd_term) begin
                trip_n   = 1'b1;
                target_n = '0;
                pflag_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            velocity     <= '0;
            target       <= '0;
            pending      <= '0;
            pending_flag <= 1'b0;
            cmd_ready    <= 1'b1;
            at_target    <= 1'b1;
            wd_tripped   <= 1'b0;
            wd_cnt       <= '0;
        end else begin
            velocity     <= vel_n;
            target       <= target_n;
            pending      <= pending_n;
            pending_flag <= pflag_n;
            cmd_ready    <= !pflag_n;
            at_target    <= (vel_n == target_n);
            wd_tripped   <= trip_n;
            wd_cnt       <= wd_cnt_n;
        end
    end

endmodule

// File: tb/tb_velocity_ramp.sv
// Bench for velocity_ramp: integer reference model checked every cycle, directed
// scenarios with hand-computed values, then randomized traffic.
module tb_velocity_ramp;

    localparam int F  = 10;
    localparam int A  = 8;
    localparam int D  = 16;
    localparam int WD = 24;
    localparam int WDMAX = (1 << WD) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [F:0]    cmd_velocity = '0;
    logic [A-1:0]  accel = '0;
    logic [D-1:0]  update_div = '0;
    logic [WD-1:0] wd_timeout = '0;
    logic          cmd_ready, tick, at_target, wd_tripped;
    logic [F:0]    velocity;

    velocity_ramp #(.F(F), .A(A), .D(D), .WD(WD)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_velocity (cmd_velocity),
        .accel        (accel),
        .update_div   (update_div),
        .wd_timeout   (wd_timeout),
        .velocity     (velocity),
        .tick         (tick),
        .at_target    (at_target),
        .wd_tripped   (wd_tripped)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference model: plain integers, updated at each rising edge.
    int m_vel, m_tgt, m_pend, m_wdc, m_div;
    bit m_pflag, m_trip, m_tick, m_at, m_ready;
    bit m_live = 0;

    function automatic int slew(input int v, input int t, input int a);
        if (t - v > a) return v + a;
        if (v - t > a) return v - a;
        return t;
    endfunction

    always @(posedge clk) begin : model
        bit acc, fire, tk;
        int nv, nt;
        if (reset) begin
            m_vel = 0; m_tgt = 0; m_pend = 0; m_pflag = 0; m_wdc = 0;
            m_trip = 0; m_div = 0; m_tick = 0; m_at = 1; m_ready = 1;
            m_live = 1;
        end else begin
            acc  = cmd_valid && m_ready;
            fire = (wd_timeout != 0) && (m_wdc == int'(wd_timeout) - 1) && !acc;
            nv   = m_tick ? slew(m_vel, m_tgt, int'(accel)) : m_vel;
            nt   = m_tgt;
            if (m_tick && m_pflag) begin
                nt = m_pend;
                m_pflag = 0;
            end
            if (acc) begin
                m_pend = int'($signed(cmd_velocity));
                m_pflag = 1; m_trip = 0; m_wdc = 0;
            end else if (m_wdc < WDMAX) begin
                m_wdc++;
            end
            if (fire) begin
                m_trip = 1; nt = 0; m_pflag = 0;
            end
            tk = (m_div >= int'(update_div));
            m_div  = tk ? 0 : m_div + 1;
            m_tick = tk;
            m_vel = nv; m_tgt = nt;
            m_at = (nv == nt);
            m_ready = !m_pflag;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("velocity", $signed(velocity), m_vel);
            chk("tick", int'(tick), int'(m_tick));
            chk("at_target", int'(at_target), int'(m_at));
            chk("wd_tripped", int'(wd_tripped), int'(m_trip));
            chk("cmd_ready", int'(cmd_ready), int'(m_ready));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int v, output int waited);
        bit r;
        logic [31:0] vv;
        vv = v;
        waited = 0;
        cmd_valid = 1'b1;
        cmd_velocity = vv[F:0];
        forever begin
            r = cmd_ready;
            cyc(1);
            if (r) break;
            waited++;
            if (waited > 1000) begin
                chk("send_timeout", waited, 0);
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    // Record the next n velocity changes (bounded by lim cycles).
    task automatic watch(input int n, input int lim, output int vals[8], output int cnt);
        int prev;
        prev = $signed(velocity);
        cnt = 0;
        for (int i = 0; i < lim && cnt < n; i++) begin
            cyc(1);
            if ($signed(velocity) != prev) begin
                prev = $signed(velocity);
                if (cnt < 8) vals[cnt] = prev;
                cnt++;
            end
        end
    endtask

    initial begin
        int w, n, cnt;
        int vals[8];

        reset = 1'b1;
        cyc(2);
        chk("rst_velocity", $signed(velocity), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_at_target", int'(at_target), 1);
        chk("rst_tick", int'(tick), 0);
        chk("rst_wd", int'(wd_tripped), 0);
        reset = 1'b0;

        // Basic ramp: 0 -> 100 in steps of 4.
        accel = 4; update_div = 0; wd_timeout = 0;
        send(100, w);
        watch(100, 200, vals, cnt);
        chk("ramp_steps", cnt, 25);
        chk("ramp_first", vals[0], 4);
        chk("ramp_second", vals[1], 8);
        chk("ramp_final", $signed(velocity), 100);
        chk("ramp_at_target", int'(at_target), 1);

        // Sign crossing 100 -> -100 at 64 per tick.
        accel = 64;
        send(-100, w);
        watch(8, 40, vals, cnt);
        chk("cross_steps", cnt, 4);
        chk("cross_0", vals[0], 36);
        chk("cross_1", vals[1], -28);
        chk("cross_2", vals[2], -92);
        chk("cross_3", vals[3], -100);
        chk("cross_at_target", int'(at_target), 1);

        // Backpressure with a slow tick.
        accel = 255; update_div = 9;
        send(50, w);
        chk("bp_ready_low", int'(cmd_ready), 0);
        send(60, w);
        chk("bp_second_waited", int'(w > 0), 1);
        cyc(60);
        chk("bp_final", $signed(velocity), 60);

        // Watchdog: trip 50 clocks after the last accept, then ramp to 0.
        update_div = 0; accel = 8; wd_timeout = 50;
        send(40, w);
        n = 0;
        while (!wd_tripped && n < 200) begin
            cyc(1);
            n++;
        end
        chk("wd_trip_clock", n, 50);
        chk("wd_vel_at_trip", $signed(velocity), 40);
        watch(8, 30, vals, cnt);
        chk("wd_steps", cnt, 5);
        chk("wd_0", vals[0], 32);
        chk("wd_4", vals[4], 0);
        send(5, w);
        chk("wd_cleared", int'(wd_tripped), 0);

        // Accept on the watchdog terminal cycle suppresses the trip.
        wd_timeout = 20;
        send(7, w);
        cyc(19);
        send(8, w);
        chk("wd_simul_no_trip", int'(wd_tripped), 0);
        cyc(5);
        chk("wd_simul_still_clear", int'(wd_tripped), 0);
        wd_timeout = 0;
        cyc(5);

        // Accept on a tick cycle: loads on the following tick, moves on the one after.
        update_div = 3; accel = 255;
        n = 0;
        while (!tick && n < 20) begin
            cyc(1);
            n++;
        end
        chk("tick_seen", int'(tick), 1);
        send(-20, w);
        n = 0;
        while ($signed(velocity) != -20 && n < 40) begin
            cyc(1);
            n++;
        end
        chk("tick_accept_latency", n, 8);

        // Reset mid-ramp.
        update_div = 0; accel = 4;
        send(200, w);
        n = 0;
        while ($signed(velocity) != 52 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("midramp_reached", $signed(velocity), 52);
        reset = 1'b1;
        cyc(1);
        chk("midrst_velocity", $signed(velocity), 0);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_tick", int'(tick), 0);
        chk("midrst_at_target", int'(at_target), 1);
        chk("midrst_wd", int'(wd_tripped), 0);
        reset = 1'b0;

        // accel = 0 freezes velocity.
        accel = 0;
        send(10, w);
        cyc(10);
        chk("freeze_velocity", $signed(velocity), 0);
        chk("freeze_at_target", int'(at_target), 0);

        // Randomized traffic against the model.
        accel = 16; update_div = 2; wd_timeout = 30;
        for (int i = 0; i < 4000; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_velocity = F'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                accel = A'($urandom);
                update_div = D'($urandom_range(0, 5));
                wd_timeout = $urandom_range(0, 1) ? '0 : WD'($urandom_range(5, 60));
            end
            reset = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        reset = 1'b0;
        cmd_valid = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
